// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory responder.
//   size_e     : access size encoding as driven on the Size port
//   state_e    : sub-word store sequencer states
//   lane_merge : splice right-aligned store data into an existing word
package mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RMW_RD,
        ST_RMW_WR
    } state_e;

    // Replace only the lanes covered by the access; word/reserved replaces everything.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] data,
        input size_e             size,
        input logic [1:0]        lane
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{lane, 3'b000} +: 8]     = data[7:0];
            SZ_HALF: merged[{lane[1], 4'b0000} +: 16] = data[15:0];
            default: merged = data;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/mem_read_pipe.sv
// Read-data delay line for the memory responder.
//   clk  : clock
//   rst  : synchronous active-high clear of every stage
//   hold : freeze all stages (used while a sub-word store is in flight)
//   din  : word entering the first stage
//   dout : word leaving the last stage, LAT edges after entry
module mem_read_pipe
    import mem_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] stage_q [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(LAT); i++) begin
                stage_q[i] <= '0;
            end
        end else if (!hold) begin
            stage_q[0] <= din;
            for (int i = 1; i < int'(LAT); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder for the multicycle CPU memory port.
// Byte-addressed, little-endian, single-port word storage. Sub-word stores
// are done as an internal read-modify-write during which Busy is high.
//   Clk        : clock
//   Reset      : synchronous active-high reset (storage is not cleared)
//   Address    : byte address
//   Wr         : 1 = write, 0 = read
//   Size       : 00 word, 01 half, 10 byte, 11 treated as word
//   Datain     : store data, sub-word data right-aligned
//   Dataout    : aligned read word, READ_LAT edges after the address sample
//   Busy       : sub-word store in progress, requests ignored
//   Misaligned : one-cycle pulse, accepted access broke size alignment
//   AddrErr    : one-cycle pulse, word index beyond DEPTH
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic        Wr,
    input  logic [1:0]  Size,
    input  logic [31:0] Datain,
    output logic [31:0] Dataout,
    output logic        Busy,
    output logic        Misaligned,
    output logic        AddrErr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];

    state_e state_q, state_d;

    size_e             req_size;
    logic [IDX_W-1:0]  req_idx;
    logic              idle;
    logic              is_sub;
    logic              addr_err;
    logic              misalign;
    logic              access_ok;
    logic              word_wr;
    logic              sub_wr;
    logic              rd_en;

    logic [IDX_W-1:0]  mem_addr;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_we;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] pipe_din;

    logic [IDX_W-1:0]  word_q;
    logic [1:0]        lane_q;
    size_e             size_q;
    logic [WORD_W-1:0] data_q;
    logic [WORD_W-1:0] merge_q;
    logic              misaligned_q;
    logic              addr_err_q;

    assign req_size = size_e'(Size);
    assign req_idx  = Address[IDX_W+1:2];
    assign idle     = (state_q == ST_IDLE);

    // Request decode; only meaningful while idle.
    always_comb begin
        is_sub   = (req_size == SZ_HALF) || (req_size == SZ_BYTE);
        addr_err = ({2'b00, Address[31:2]} >= DEPTH);
        unique case (req_size)
            SZ_HALF: misalign = Address[0];
            SZ_BYTE: misalign = 1'b0;
            default: misalign = |Address[1:0];
        endcase
        access_ok = idle && !addr_err && !misalign;
        word_wr   = access_ok && Wr && !is_sub;
        sub_wr    = access_ok && Wr && is_sub;
        rd_en     = access_ok && !Wr;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (sub_wr) state_d = ST_RMW_RD;
            ST_RMW_RD: state_d = ST_RMW_WR;
            ST_RMW_WR: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // One shared port: the live request owns it when idle, the RMW sequence otherwise.
    always_comb begin
        mem_addr  = idle ? req_idx : word_q;
        mem_we    = 1'b0;
        mem_wdata = Datain;
        if (word_wr) begin
            mem_we = 1'b1;
        end else if (state_q == ST_RMW_WR) begin
            mem_we    = 1'b1;
            mem_wdata = lane_merge(merge_q, data_q, size_q, lane_q);
        end
    end

    assign mem_rdata = mem[mem_addr];

    // Storage is never reset, but no write lands while Reset is held.
    always_ff @(posedge Clk) begin
        if (mem_we && !Reset) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (state_q == ST_RMW_RD) begin
            merge_q <= mem_rdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            lane_q       <= '0;
            size_q       <= SZ_WORD;
            data_q       <= '0;
            misaligned_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= idle && misalign;
            addr_err_q   <= idle && addr_err;
            if (sub_wr) begin
                word_q <= req_idx;
                lane_q <= Address[1:0];
                size_q <= req_size;
                data_q <= Datain;
            end
        end
    end

    // Suppressed reads and write slots carry zero down the pipe.
    assign pipe_din = rd_en ? mem_rdata : '0;

    mem_read_pipe #(
        .LAT (READ_LAT)
    ) u_read_pipe (
        .clk  (Clk),
        .rst  (Reset),
        .hold (Busy),
        .din  (pipe_din),
        .dout (Dataout)
    );

    assign Busy       = !idle;
    assign Misaligned = misaligned_q;
    assign AddrErr    = addr_err_q;

endmodule
